// File: rtl/heap_update_scheduler.sv
// rtl/heap_update_scheduler.sv - replace-root scheduler for a pipelined heap of sorting nodes
module heap_update_scheduler #(
  parameter int WIDTH  = 15,
  parameter int LEVELS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              op_valid,
  input  logic [WIDTH:0]    op_data,
  output logic              op_ready,
  output logic [WIDTH:0]    result_data,
  output logic              result_valid,
  input  logic [WIDTH:0]    root_q,
  output logic [WIDTH:0]    root_data,
  output logic              root_wren,
  output logic              initialize,
  output logic              update_launch,
  input  logic [LEVELS-1:0] node_done,
  input  logic [LEVELS-1:0] node_swap,
  output logic              busy,
  output logic              wave_err
);

  typedef enum logic [2:0] {IDLE, INIT, READY, READ, WRITE, LAUNCH} state_t;

  state_t            state, state_nx;
  logic [LEVELS-1:0] tok, tok_set, tok_clr, tok_nx, stray;
  logic [WIDTH:0]    op_reg, res_reg;
  logic              accept;

  always_comb begin
    state_nx      = state;
    op_ready      = 1'b0;
    result_valid  = 1'b0;
    root_wren     = 1'b0;
    initialize    = 1'b0;
    update_launch = 1'b0;
    case (state)
      IDLE:   state_nx = INIT;
      INIT: begin
        initialize = 1'b1;
        state_nx   = READY;
      end
      READY: begin
        // keep two free levels ahead of a new wavefront
        op_ready = ~tok[0] & ~tok[1];
        if (op_valid && op_ready) state_nx = READ;
      end
      READ:   state_nx = WRITE;
      WRITE: begin
        result_valid = 1'b1;
        root_wren    = 1'b1;
        state_nx     = LAUNCH;
      end
      LAUNCH: begin
        update_launch = 1'b1;
        state_nx      = READY;
      end
      default: state_nx = IDLE;
    endcase
    // a cycle with reset low must never write the root or hand out a result
    if (!rst) begin
      op_ready      = 1'b0;
      result_valid  = 1'b0;
      root_wren     = 1'b0;
      initialize    = 1'b0;
      update_launch = 1'b0;
    end
  end

  assign accept = op_valid & op_ready;

  always_comb begin
    tok_clr    = node_done & tok;
    stray      = node_done & ~tok;
    tok_set    = '0;
    tok_set[0] = (state == LAUNCH);
    for (int i = 1; i < LEVELS; i++) begin
      tok_set[i] = tok_clr[i-1] & node_swap[i-1];
    end
    tok_nx = tok_set | (tok & ~tok_clr);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      tok      <= '0;
      op_reg   <= '0;
      res_reg  <= '0;
      wave_err <= 1'b0;
    end else begin
      state <= state_nx;
      tok   <= tok_nx;
      if (accept) op_reg <= op_data;
      if (state == WRITE) res_reg <= root_q;
      if (|stray) wave_err <= 1'b1;
    end
  end

  // result_data follows root_q while WRITE pulses, then holds the displaced record
  assign result_data = !rst ? '0 : ((state == WRITE) ? root_q : res_reg);
  assign root_data   = rst ? op_reg : '0;
  assign busy        = (|tok) || (state == READ) || (state == WRITE) || (state == LAUNCH);

endmodule

// File: tb/tb_heap_update_scheduler.sv
// tb/tb_heap_update_scheduler.sv - randomized bench for heap_update_scheduler with a wavefront model
module tb_heap_update_scheduler;
  localparam int W = 15;
  localparam int L = 4;

  logic         clk = 1'b0;
  logic         rst, op_valid, op_ready, result_valid, root_wren;
  logic         initialize, update_launch, busy, wave_err;
  logic [W:0]   op_data, result_data, root_q, root_data;
  logic [L-1:0] node_done, node_swap;

  always #5 clk = ~clk;

  heap_update_scheduler #(.WIDTH(W), .LEVELS(L)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_data(op_data), .op_ready(op_ready),
    .result_data(result_data), .result_valid(result_valid), .root_q(root_q),
    .root_data(root_data), .root_wren(root_wren), .initialize(initialize),
    .update_launch(update_launch), .node_done(node_done), .node_swap(node_swap),
    .busy(busy), .wave_err(wave_err)
  );

  // single-word root RAM with one cycle read latency
  logic [W:0] mem = 16'h0005;
  always @(posedge clk) begin
    if (root_wren) mem <= root_data;
    root_q <= mem;
  end

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // reference model: wavefront occupancy per level, cycles since acceptance, cycles since release
  bit         occ[L];
  int         since = -1;
  int         rel = 0;
  bit         err = 0;
  logic [W:0] pend = '0;
  logic [W:0] last_root = 16'h0005;

  task automatic step(input bit r, input bit v, input logic [W:0] d,
                      input logic [L-1:0] dn, input logic [L-1:0] sw);
    bit exp_ready, any;
    bit nocc[L];
    @(posedge clk);
    #1;
    rst = r; op_valid = v; op_data = d; node_done = dn; node_swap = sw;
    #1;
    any = 1'b0;
    for (int i = 0; i < L; i++) any |= occ[i];
    exp_ready = r && rel >= 2 && since < 0 && !occ[0] && !occ[1];
    check_val("op_ready", op_ready, exp_ready);
    check_val("initialize", initialize, r && rel == 1);
    check_val("result_valid", result_valid, r && since == 2);
    check_val("root_wren", root_wren, r && since == 2);
    check_val("update_launch", update_launch, r && since == 3);
    check_val("wave_err", wave_err, err);
    check_val("busy", busy, any || since >= 1);
    if (r && since == 2) begin
      check_val("result_data", result_data, last_root);
      check_val("root_data", root_data, pend);
    end
    if (!r) begin
      check_val("result_data_rst", result_data, 0);
      check_val("root_data_rst", root_data, 0);
    end
    if (!r) begin
      for (int i = 0; i < L; i++) occ[i] = 1'b0;
      since = -1; rel = 0; err = 1'b0;
    end else begin
      for (int i = 0; i < L; i++) if (dn[i] && !occ[i]) err = 1'b1;
      nocc = occ;
      for (int i = 0; i < L; i++) if (dn[i] && occ[i]) nocc[i] = 1'b0;
      for (int i = 0; i < L - 1; i++) if (dn[i] && occ[i] && sw[i]) nocc[i+1] = 1'b1;
      if (since == 3) nocc[0] = 1'b1;
      occ = nocc;
      if (since == 2) last_root = pend;
      if (since >= 1) since = (since == 3) ? -1 : since + 1;
      else if (exp_ready && v) begin
        since = 1;
        pend  = d;
      end
      if (rel < 2) rel++;
    end
  endtask

  // plays the sorting nodes: finish occupied levels at random, never advancing into a held level
  task automatic gen_nodes(output logic [L-1:0] dn, output logic [L-1:0] sw);
    bit tgt[L];
    bit s;
    dn = '0; sw = '0;
    tgt = occ;
    for (int i = L - 1; i >= 0; i--) begin
      if (occ[i] && $urandom_range(0, 2) == 0) begin
        dn[i] = 1'b1;
        s = 1'($urandom_range(0, 1));
        if (s && i < L - 1 && tgt[i+1]) s = 1'b0;
        sw[i]  = s;
        tgt[i] = 1'b0;
        if (s && i < L - 1) tgt[i+1] = 1'b1;
      end
    end
  endtask

  initial begin
    logic [L-1:0] dn, sw;
    bit           r, v;
    rst = 1'b0; op_valid = 1'b0; op_data = '0; node_done = '0; node_swap = '0;
    repeat (2) @(posedge clk);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    check_val("busy_rst", busy, 0);

    step(1, 0, 0, 0, 0);
    check_val("init_c1", initialize, 0);
    step(1, 0, 0, 0, 0);
    check_val("init_c2", initialize, 1);
    step(1, 1, 16'h7FFF, 0, 0);
    check_val("ready_c3", op_ready, 1);
    step(1, 0, 16'h1111, 0, 0);
    step(1, 0, 0, 0, 0);
    check_val("write_res", result_data, 16'h0005);
    check_val("write_root", root_data, 16'h7FFF);
    step(1, 0, 0, 0, 0);
    check_val("launch_3cyc", update_launch, 1);
    step(1, 1, 16'h1234, 0, 0);
    check_val("tok0_block", op_ready, 0);
    step(1, 1, 16'h1234, 4'b0001, 4'b0001);
    step(1, 1, 16'h1234, 0, 0);
    check_val("tok1_block", op_ready, 0);
    step(1, 0, 0, 4'b0010, 4'b0000);
    step(1, 0, 0, 0, 0);
    check_val("idle_busy", busy, 0);
    check_val("idle_ready", op_ready, 1);

    step(1, 0, 0, 4'b0100, 0);
    step(1, 0, 0, 0, 0);
    check_val("err_set", wave_err, 1);
    for (int k = 0; k < 60; k++) begin
      gen_nodes(dn, sw);
      step(1, 1'($urandom_range(0, 1)), W'($urandom), dn, sw);
    end
    check_val("err_sticky", wave_err, 1);

    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 1, 16'h0ABC, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    check_val("abort_wren", root_wren, 0);
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    check_val("reinit", initialize, 1);

    for (int k = 0; k < 4000; k++) begin
      r = ($urandom_range(0, 799) != 0);
      v = 1'($urandom_range(0, 1));
      gen_nodes(dn, sw);
      step(r, v, W'($urandom), dn, sw);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule

// File: doc/heap_update_scheduler.md
HEAP_UPDATE_SCHEDULER -- requirements
Module: heap_update_scheduler

Interface
REQ-001 SHALL have parameter WIDTH, default 15, meaning record MSB index; records are WIDTH+1 bits.
REQ-002 SHALL have parameter LEVELS, default 4, meaning number of sorting-node levels below the root (2..16).
REQ-003 SHALL have port clk  input  1  the single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset; one clock, synchronous, active-low (rst=0 resets).
REQ-005 SHALL have port op_valid  input  1  host requests replace-root.
REQ-006 SHALL have port op_data  input  WIDTH+1  new root record.
REQ-007 SHALL have port op_ready  output  1  host operation accepted when op_valid and op_ready are both high in a cycle.
REQ-008 SHALL have port result_data  output  WIDTH+1  root record displaced by the last accepted operation.
REQ-009 SHALL have port result_valid  output  1  one-cycle pulse qualifying result_data.
REQ-010 SHALL have port root_q  input  WIDTH+1  root RAM read data, valid one cycle after the read.
REQ-011 SHALL have port root_data / root_wren  output  WIDTH+1 / 1  root RAM write data and enable.
REQ-012 SHALL have port initialize  output  1  to all sorting nodes.
REQ-013 SHALL have port update_launch  output  1  one-cycle pulse to the level-1 node update_in.
REQ-014 SHALL have port node_done  input  LEVELS  bit i pulses when level i finishes its compare.
REQ-015 SHALL have port node_swap  input  LEVELS  bit i = level i update_out, sampled with node_done[i].
REQ-016 SHALL have port busy / wave_err  output  1 / 1  any wavefront in flight; sticky protocol error.

Function
REQ-017 SHALL implement FSM states IDLE, INIT, READY, READ, WRITE, LAUNCH.
REQ-018 IDLE SHALL go to INIT on the first cycle after reset is released; INIT SHALL drive initialize=1 for exactly one cycle and then go to READY.
REQ-019 op_ready SHALL be 1 only in READY with tok[0]=0 and tok[1]=0 (LEVELS>=2).
REQ-020 On acceptance, the block SHALL register op_data and go to READY->READ; READ SHALL wait one cycle for root_q.
REQ-021 WRITE SHALL capture root_q into result_data, pulse result_valid, and drive root_wren=1 with root_data=registered op_data, all for one cycle.
REQ-022 LAUNCH SHALL pulse update_launch for one cycle, set tok[0], and return to READY; accept-to-launch latency is 3 cycles.
REQ-023 tok[LEVELS-1:0] SHALL be a wavefront occupancy vector: on node_done[i] with tok[i]=1, tok[i] clears; if node_swap[i]=1 and i<LEVELS-1, tok[i+1] sets next cycle.
REQ-024 When a set and a clear of the same tok bit occur in one cycle, set SHALL win.
REQ-025 A swap reported at level LEVELS-1 SHALL retire the wavefront (no further token).
REQ-026 node_done[i] with tok[i]=0 SHALL set wave_err, leave tok unchanged, and hold wave_err until reset.
REQ-027 busy SHALL equal OR of tok bits, or FSM in READ/WRITE/LAUNCH.
REQ-028 Multiple wavefronts SHALL coexist in the pipeline, separated by at least two levels per REQ-019.
REQ-029 op_valid outside an accepting cycle SHALL be ignored with no state change; op_data need not be held after acceptance.

Reset
REQ-030 While rst=0 the block SHALL enter IDLE; tok, result_data, root_data, and wave_err SHALL be 0; op_ready, result_valid, root_wren, initialize, and update_launch SHALL be 0.
REQ-031 Reset asserted mid-operation SHALL abort it on the next edge without a root write; reinitialize through INIT.

Verification
REQ-032 Release reset -> initialize high exactly 1 cycle (cycle 2), op_ready=1 from cycle 3.
REQ-033 root_q=0x0005, op accepted with op_data=0x7FFF -> result_data=0x0005 with result_valid pulse, root_wren with 0x7FFF, update_launch 3 cycles after accept.
REQ-034 Following an op with LEVELS=4, node_done[0] with node_swap[0]=1, then node_done[1] with node_swap[1]=0 -> tok goes 0001, 0010, 0000; op_ready low until tok[1:0]=0; busy falls after the last clear.
REQ-035 Second op_valid held while tok[0]=1 -> not accepted; accepted the cycle tok[1:0] clears; two wavefronts tracked concurrently, both retire at level 3.
REQ-036 node_done[2] pulse with tok=0000 -> wave_err=1 and stays 1 through ops until rst=0.
REQ-037 rst=0 asserted in WRITE state -> no root_wren, all outputs 0 next cycle, INIT pulse repeats after release.
